// File: rtl/dmem_readback_pkg.sv
// Shared types and default sizes for the data-memory readback engine.
// The FSM states and default geometry live here.
package dmem_readback_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_RD_LAT = 2;

  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD,
    DONE
  } state_e;

endpackage

// File: rtl/dmem_readback_lat.sv
// lat_counter: counts read-latency cycles.
// tc_o is high on the cycle whose edge completes the wait.
module lat_counter
  import dmem_readback_pkg::*;
#(
  parameter int LAT = DEF_RD_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [LAT_CNT_W-1:0] TC =
    LAT_CNT_W'(LAT - 1);

  logic [LAT_CNT_W-1:0] cnt_q;
  logic [LAT_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == TC);

endmodule

// File: rtl/dmem_readback.sv
// Walks a window of processor data memory and streams
// each word out over a valid/ready beat interface.
module dmem_readback
  import dmem_readback_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] inaddress,
  input  logic [DATA_W-1:0] outdata,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W:0]   rem_q, rem_d;

  logic lat_clr;
  logic lat_en;
  logic lat_tc;

  // Counter runs only in WAIT and restarts from zero on every entry.
  assign lat_en  = (state_q == WAIT);
  assign lat_clr = !lat_en;

  lat_counter #(
    .LAT (RD_LAT)
  ) u_lat (
    .clk   (clk),
    .reset (reset),
    .clr_i (lat_clr),
    .en_i  (lat_en),
    .tc_o  (lat_tc)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    daddr_d = daddr_q;
    valid_d = valid_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            addr_d  = base_addr;
            rem_d   = count;
            state_d = WAIT;
          end else begin
            state_d = DONE;
          end
        end
      end
      WAIT: begin
        if (lat_tc) begin
          data_d  = outdata;
          daddr_d = addr_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (dump_ready) begin
          valid_d = 1'b0;
          rem_d   = rem_q - 1'b1;
          if (rem_q == ONE) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = WAIT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      daddr_q <= '0;
      valid_q <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      daddr_q <= daddr_d;
      valid_q <= valid_d;
      rem_q   <= rem_d;
    end
  end

  assign inaddress  = addr_q;
  assign dump_data  = data_q;
  assign dump_addr  = daddr_q;
  assign dump_valid = valid_q;
  assign dump_last  = valid_q && (rem_q == ONE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: doc/dmem_readback.md
DMEM_READBACK -- requirements
Module: dmem_readback

Interface
REQ-001 Parameter ADDR_W, default 10, processor data-memory address width (matches inaddress).
REQ-002 Parameter DATA_W, default 16, read-data width (matches outdata).
REQ-003 Parameter RD_LAT, default 2, cycles from inaddress change to stable outdata; legal range 1..15.
REQ-004 Port clk  input  1  system clock; all state on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port start  input  1  single-cycle request to begin a dump; sampled in IDLE only.
REQ-007 Port base_addr  input  ADDR_W  first address of the dump; captured with start.
REQ-008 Port count  input  ADDR_W+1  number of words to read, 0..1024; captured with start.
REQ-009 Port inaddress  output  ADDR_W  registered address to the processor's memory read port.
REQ-010 Port outdata  input  DATA_W  processor read data for inaddress.
REQ-011 Port dump_data  output  DATA_W  captured word.
REQ-012 Port dump_addr  output  ADDR_W  address dump_data was read from.
REQ-013 Port dump_valid  output  1  beat valid.
REQ-014 Port dump_ready  input  1  downstream accepts the beat.
REQ-015 Port dump_last  output  1  marks the final beat; qualified by dump_valid.
REQ-016 Port busy  output  1  high from the edge that accepts start until the done pulse ends.
REQ-017 Port done  output  1  one-cycle pulse when the dump completes.

Function
REQ-018 FSM states: IDLE, WAIT, HOLD, DONE.
REQ-019 IDLE: on an edge with start=1 and count>0, capture base_addr and count, drive inaddress<=base_addr, clear wait counter, and go to WAIT.
REQ-020 IDLE: start=1 with count=0 goes to DONE directly and emits no beats.
REQ-021 WAIT: the counter increments each edge; at the RD_LAT-th edge after entry, capture dump_data<=outdata and dump_addr<=inaddress, set dump_valid=1, and go to HOLD.
REQ-022 The first dump_valid therefore rises RD_LAT edges after the edge that accepted start.
REQ-023 HOLD: dump_valid, dump_data, dump_addr and dump_last hold stable until an edge with dump_ready=1.
REQ-024 HOLD handshake on a non-final beat: clear dump_valid, set inaddress<=inaddress+1, and return to WAIT; peak throughput is one beat per RD_LAT+1 cycles.
REQ-025 HOLD handshake on the final beat: clear dump_valid and go to DONE.
REQ-026 dump_last=1 exactly when the remaining-count register equals 1 while dump_valid=1.
REQ-027 Address increment wraps modulo 2^ADDR_W (1023+1 -> 0), with no error indication.
REQ-028 DONE lasts one cycle with done=1, then returns to IDLE; busy is also high in this cycle.
REQ-029 start is ignored in every state other than IDLE, including the DONE cycle.
REQ-030 dump_ready while dump_valid=0 has no effect.
REQ-031 inaddress changes only on the start-acceptance edge and on non-final handshakes; at all other times it holds its last value.

Reset
REQ-032 Asserting reset forces IDLE immediately, independent of clk.
REQ-033 Reset values: inaddress=0, dump_data=0, dump_addr=0, dump_valid=0, dump_last=0, busy=0, done=0; counters are cleared.
REQ-034 Reset during WAIT or HOLD abandons the dump; no done pulse is produced, and the first post-reset start begins a fresh dump.

Structure
REQ-035 Package dmem_readback_pkg holds the state enum and the default ADDR_W, DATA_W and RD_LAT constants.
REQ-036 One sub-module, lat_counter, implements the RD_LAT wait counter (clear, enable, terminal-count output); all other logic lives in dmem_readback.

Verification
REQ-037 Reset test: with memory mem[0]=48, mem[1]=18, mem[2]=6, base=0, count=3, ready=1 -> beats (0,48), (1,18), (2,6); last only on the third beat; done is one cycle after the third handshake; busy then drops.
REQ-038 Backpressure test: same dump with ready held low 5 cycles on beat 2 -> dump_data=18, dump_addr=1 and dump_valid stay stable for all 5 cycles; inaddress stays 1; beat order is unchanged.
REQ-039 Wrap test: base=1023, count=2 -> beats at addresses 1023 then 0; last on the second beat.
REQ-040 Zero-count test: count=0 -> no dump_valid ever; done pulses on the edge after start; busy is high for exactly one cycle.
REQ-041 Reset mid-dump: assert reset while in HOLD of beat 2 -> all outputs 0 immediately and no done pulse; a new start with base=2, count=1 yields the single beat (2,6) with last=1.
REQ-042 Start-while-busy: pulse start with base=5 during the dump -> ignored; the addresses emitted are unchanged.
